// File: rtl/i2c_ctrl_if.sv
// Open-drain I2C bus. Each side only asserts a pull-low request.
// A line reads high unless some side pulls it low, which models the external pull-ups.
interface i2c_if;
  logic m_sda_low;
  logic m_scl_low;
  logic s_sda_low;
  logic s_scl_low;
  wire  sda;
  wire  scl;

  assign sda = !(m_sda_low || s_sda_low);
  assign scl = !(m_scl_low || s_scl_low);

  modport master (output m_sda_low, output m_scl_low, input sda, input scl);
  modport slave  (output s_sda_low, output s_scl_low, input sda, input scl);
endinterface

// File: rtl/i2c_ctrl.sv
// Single-transaction I2C master: START, address byte, one write or read byte, STOP.
// Each bit is four phases of QDIV clocks; sda/scl are only ever pulled low or released.
module i2c_ctrl #(
  parameter int unsigned QDIV = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [7:0] addr,
  inout  wire  [7:0] data,
  i2c_if.master      i2c
);

  localparam int unsigned QW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, MNACK, STOP
  } state_t;

  state_t          r_state;
  logic [1:0]      r_phase;
  logic [QW-1:0]   r_qcnt;
  logic [2:0]      r_bit;
  logic            r_en_d;
  logic [7:0]      r_addr;
  logic [7:0]      r_wdata;
  logic [7:0]      r_shift;
  logic [7:0]      r_rdata;
  logic            r_sda_low;
  logic            r_scl_low;

  logic            w_tick;
  logic            w_start;
  logic            w_stall;
  logic            w_sda_in;
  logic [2:0]      w_bit_m1;

  assign w_tick   = (r_qcnt == QLAST);
  assign w_start  = (r_state == IDLE) && en && !r_en_d;
  assign w_sda_in = i2c.sda;
  assign w_bit_m1 = r_bit - 3'd1;
  // A slave holding scl low after release stretches the current phase.
  assign w_stall  = (r_state != IDLE) && !r_scl_low && !i2c.scl;

  assign i2c.m_sda_low = r_sda_low;
  assign i2c.m_scl_low = r_scl_low;
  assign data = addr[0] ? r_rdata : 8'bz;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state   <= IDLE;
      r_phase   <= '0;
      r_qcnt    <= '0;
      r_bit     <= '0;
      r_en_d    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_shift   <= '0;
      r_rdata   <= '0;
      r_sda_low <= 1'b0;
      r_scl_low <= 1'b0;
    end else begin
      r_en_d <= en;
      if (r_state == IDLE) begin
        r_phase   <= '0;
        r_qcnt    <= '0;
        r_sda_low <= 1'b0;
        r_scl_low <= 1'b0;
        if (w_start) begin
          r_state <= START;
          r_addr  <= addr;
          r_wdata <= data;
        end
      end else if (w_stall) begin
        r_qcnt <= r_qcnt;
      end else if (!w_tick) begin
        r_qcnt <= r_qcnt + QW'(1);
      end else begin
        r_qcnt  <= '0;
        r_phase <= r_phase + 2'd1;
        case (r_state)
          START: begin
            case (r_phase)
              2'd0: r_sda_low <= 1'b1;
              2'd1: r_scl_low <= 1'b1;
              default: begin
                r_phase   <= '0;
                r_bit     <= 3'd7;
                r_sda_low <= !r_addr[7];
                r_state   <= ADDR;
              end
            endcase
          end
          STOP: begin
            case (r_phase)
              2'd0: r_scl_low <= 1'b0;
              2'd1: r_sda_low <= 1'b0;
              default: begin
                r_phase <= '0;
                r_state <= IDLE;
              end
            endcase
          end
          default: begin
            if (r_phase == 2'd1) r_scl_low <= 1'b0;
            // End of P3: sda was sampled this edge, set up the next bit's P0.
            if (r_phase == 2'd3) begin
              r_scl_low <= 1'b1;
              r_sda_low <= 1'b0;
              r_bit     <= w_bit_m1;
              case (r_state)
                ADDR: begin
                  if (r_bit == 3'd0) r_state <= AACK;
                  else               r_sda_low <= !r_addr[w_bit_m1];
                end
                AACK: begin
                  r_bit <= 3'd7;
                  if (w_sda_in) begin
                    r_state   <= STOP;
                    r_sda_low <= 1'b1;
                  end else if (r_addr[0]) begin
                    r_state <= RDATA;
                  end else begin
                    r_state   <= WDATA;
                    r_sda_low <= !r_wdata[7];
                  end
                end
                WDATA: begin
                  if (r_bit == 3'd0) r_state <= WACK;
                  else               r_sda_low <= !r_wdata[w_bit_m1];
                end
                WACK: begin
                  r_state   <= STOP;
                  r_sda_low <= 1'b1;
                end
                RDATA: begin
                  r_shift <= {r_shift[6:0], w_sda_in};
                  if (r_bit == 3'd0) begin
                    r_rdata <= {r_shift[6:0], w_sda_in};
                    r_state <= MNACK;
                  end
                end
                MNACK: begin
                  r_state   <= STOP;
                  r_sda_low <= 1'b1;
                end
                default: r_state <= IDLE;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_ctrl.sv
// Directed bench for i2c_ctrl: a bus monitor/slave logs START/bit/STOP events,
// which are checked against an expected-event queue filled when each transaction is launched.
module tb_i2c_ctrl;

  localparam logic [1:0] EV_START = 2'd2;
  localparam logic [1:0] EV_STOP  = 2'd3;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       en = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] tb_wdata = 8'h00;
  wire  [7:0] data;

  i2c_if bus ();

  assign data = addr[0] ? 8'bz : tb_wdata;
  assign bus.s_scl_low = 1'b0;

  i2c_ctrl #(.QDIV(1)) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .addr (addr),
    .data (data),
    .i2c  (bus.master)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err = 0;

  logic [1:0]  exp_q[$];
  logic [1:0]  obs_q[$];
  int unsigned rise_q[$];

  int unsigned cyc = 0;
  int unsigned start_cnt = 0;
  int unsigned stop_cnt = 0;
  int unsigned stop_cyc = 0;
  int unsigned bitn = 0;

  logic       sl_ack_addr = 1'b1;
  logic       sl_ack_data = 1'b1;
  logic [7:0] sl_rd = 8'h00;

  logic p_sda = 1'b1, p_scl = 1'b1, hi_valid = 1'b0, hi_sda = 1'b1, rw = 1'b0;

  // Bus monitor plus slave responder; bitn counts bits completed since START.
  always @(negedge clk) begin
    cyc++;
    if (rstn) begin
      bus.s_sda_low = 1'b0;
      hi_valid = 1'b0;
    end else begin
      if (p_scl && bus.scl && p_sda && !bus.sda) begin
        obs_q.push_back(EV_START); start_cnt++; bitn = 0; hi_valid = 1'b0;
      end else if (p_scl && bus.scl && !p_sda && bus.sda) begin
        obs_q.push_back(EV_STOP); stop_cnt++; stop_cyc = cyc; hi_valid = 1'b0;
      end
      if (!p_scl && bus.scl) begin
        hi_valid = 1'b1; hi_sda = bus.sda; rise_q.push_back(cyc);
      end
      if (p_scl && !bus.scl) begin
        if (hi_valid) begin
          obs_q.push_back({1'b0, hi_sda});
          if (bitn == 7) rw = hi_sda;
          bitn++;
        end
        hi_valid = 1'b0;
        if (bitn == 8)                           bus.s_sda_low = sl_ack_addr;
        else if (rw && bitn >= 9 && bitn <= 16)  bus.s_sda_low = !sl_rd[16 - bitn];
        else if (!rw && bitn == 17)              bus.s_sda_low = sl_ack_data;
        else                                     bus.s_sda_low = 1'b0;
      end
    end
    p_sda = bus.sda;
    p_scl = bus.scl;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, b[i]});
  endtask

  // Expected bus events of a full transaction, derived from the protocol.
  task automatic push_txn(input logic [7:0] a, input logic [7:0] d, input logic ack_a, input logic ack_d);
    exp_q.push_back(EV_START);
    push_byte(a);
    exp_q.push_back({1'b0, !ack_a});
    if (ack_a) begin
      push_byte(d);
      exp_q.push_back(a[0] ? 2'd1 : {1'b0, !ack_d});
    end
    exp_q.push_back(EV_STOP);
  endtask

  task automatic wait_stop(input string tag, input int unsigned prev);
    int unsigned n = 0;
    while (stop_cnt == prev && n < 400) begin
      @(posedge clk); n++;
    end
    chk({tag, "_stop_seen"}, 32'(stop_cnt != prev), 32'd1);
  endtask

  task automatic check_events(input string tag);
    int unsigned n = 0;
    logic [1:0] o, e;
    while (obs_q.size() < exp_q.size() && n < 200) begin
      @(posedge clk); n++;
    end
    chk({tag, "_event_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_event"}, 32'(o), 32'(e));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic pulse_en();
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
  endtask

  int unsigned t0, s0, n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_released", 32'(bus.m_sda_low), 32'd0);
    chk("rst_scl_released", 32'(bus.m_scl_low), 32'd0);
    @(negedge clk) rstn = 1'b0;
    addr = 8'hAF;
    @(posedge clk); #1;
    chk("rst_rdata_zero", 32'(data), 32'h00);
    chk("rst_sda_high", 32'(bus.sda), 32'd1);
    chk("rst_scl_high", 32'(bus.scl), 32'd1);
    obs_q.delete();

    // Read 0xAF, slave returns 0xDD; en stays high afterwards.
    sl_ack_addr = 1'b1; sl_rd = 8'hDD;
    push_txn(8'hAF, 8'hDD, 1'b1, 1'b1);
    rise_q.delete();
    s0 = stop_cnt;
    @(negedge clk) en = 1'b1;
    @(posedge clk) t0 = cyc;
    wait_stop("read", s0);
    chk("read_len_le_84", 32'((stop_cyc - t0) <= 84), 32'd1);
    chk("bit_period_a", rise_q[1] - rise_q[0], 32'd4);
    chk("bit_period_b", rise_q[12] - rise_q[11], 32'd4);
    check_events("read");
    chk("read_data", 32'(data), 32'hDD);

    // en held high: no second transaction.
    s0 = start_cnt;
    repeat (150) @(posedge clk);
    chk("en_hold_no_restart", start_cnt, s0);
    @(negedge clk) en = 1'b0;

    // Write 0xAE / 0x55, both acked.
    addr = 8'hAE; tb_wdata = 8'h55; sl_ack_addr = 1'b1; sl_ack_data = 1'b1;
    push_txn(8'hAE, 8'h55, 1'b1, 1'b1);
    s0 = stop_cnt;
    pulse_en();
    wait_stop("write", s0);
    check_events("write");
    addr = 8'hAF;
    @(posedge clk); #1;
    chk("rdata_held", 32'(data), 32'hDD);

    // Address NACK: STOP right after the address byte.
    addr = 8'hA0; tb_wdata = 8'h33; sl_ack_addr = 1'b0;
    push_txn(8'hA0, 8'h33, 1'b0, 1'b1);
    s0 = stop_cnt;
    pulse_en();
    wait_stop("nack", s0);
    check_events("nack");

    // Low-then-high en starts exactly one more read.
    addr = 8'hAF; sl_ack_addr = 1'b1; sl_rd = 8'h3C;
    push_txn(8'hAF, 8'h3C, 1'b1, 1'b1);
    s0 = start_cnt;
    t0 = stop_cnt;
    @(negedge clk) en = 1'b1;
    wait_stop("repulse", t0);
    check_events("repulse");
    repeat (150) @(posedge clk);
    chk("repulse_one_start", start_cnt, s0 + 1);
    chk("repulse_data", 32'(data), 32'h3C);
    @(negedge clk) en = 1'b0;
    repeat (4) @(posedge clk);

    // Reset during address bit 4.
    exp_q.push_back(EV_START);
    exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    exp_q.push_back(2'd1); exp_q.push_back(2'd0);
    s0 = start_cnt;
    @(negedge clk) en = 1'b1;
    n = 0;
    while (!(start_cnt == s0 + 1 && bitn == 4) && n < 200) begin
      @(posedge clk); n++;
    end
    chk("abort_reached_bit4", 32'(bitn), 32'd4);
    t0 = stop_cnt;
    @(negedge clk) rstn = 1'b1;
    #1;
    chk("abort_sda_released", 32'(bus.m_sda_low), 32'd0);
    chk("abort_scl_released", 32'(bus.m_scl_low), 32'd0);
    chk("abort_sda_high", 32'(bus.sda), 32'd1);
    chk("abort_scl_high", 32'(bus.scl), 32'd1);
    chk("abort_data_zero", 32'(data), 32'h00);
    en = 1'b0;
    repeat (6) @(posedge clk);
    chk("abort_no_stop", stop_cnt, t0);
    check_events("abort");
    @(negedge clk) rstn = 1'b0;
    repeat (3) @(posedge clk);

    // Normal operation resumes after reset.
    addr = 8'hAE; tb_wdata = 8'h81; sl_ack_addr = 1'b1; sl_ack_data = 1'b0;
    push_txn(8'hAE, 8'h81, 1'b1, 1'b0);
    s0 = stop_cnt;
    pulse_en();
    wait_stop("resume", s0);
    check_events("resume");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
